// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
//   Write-side bus of the 7-segment scan controller. The host (master) pushes
//   decoded character codes and issues buffer clears; the controller (slave)
//   reports through wr_ready whether a write is accepted this cycle.
//
//   wr_en    host -> ctrl  write strobe, accepted only while wr_ready = 1
//   wr_data  host -> ctrl  4-bit character code (0..9, others use decoder default)
//   clr      host -> ctrl  single-cycle synchronous buffer clear
//   wr_ready ctrl -> host  registered, 1 = a write presented now is accepted
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       clr;
  logic       wr_ready;

  modport master (
    output wr_en,
    output wr_data,
    output clr,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  clr,
    output wr_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed 7-segment display controller. Holds up to NUM_DIGITS
//   character codes in a shift buffer (newest digit in entry 0) and scans the
//   digits one slot at a time. Each slot lasts SCAN_DIV cycles: the first
//   BLANK_CYCLES cycles drive every digit off (ghosting guard), the rest light
//   the digit of the current slot if that buffer entry holds a valid digit.
//
// Parameters
//   NUM_DIGITS    number of multiplexed digits, 2..8
//   SCAN_DIV      clock cycles per digit slot
//   BLANK_CYCLES  all-off guard cycles at the start of each slot,
//                 1 <= BLANK_CYCLES < SCAN_DIV
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   bus        write bus (slave side): wr_en, wr_data, clr in; wr_ready out
//   digit_key  registered code of the scanned digit (4'hF when empty)
//   seg_en     registered active-low digit enables, bits >= NUM_DIGITS held 1
//   scan_idx   registered index of the current digit slot
//   buf_count  registered number of valid digits, 0..NUM_DIGITS
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus,
  output logic [3:0]      digit_key,
  output logic [7:0]      seg_en,
  output logic [2:0]      scan_idx,
  output logic [3:0]      buf_count
);

  localparam int              CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]      COUNT_FULL = 4'(NUM_DIGITS);
  localparam logic [3:0]      EMPTY_CODE = 4'hF;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  // ---------------------------------------------------------------------------
  // Digit buffer and write handshake
  // ---------------------------------------------------------------------------
  logic [3:0] digit_buf [NUM_DIGITS];
  logic [3:0] count_q;
  logic       ready_q;
  logic       accept;

  // clr has priority: a write presented in the same cycle is dropped.
  assign accept = bus.wr_en && ready_q && !bus.clr;

  // NOTE: the buffer is a handful of flops, not RAM, so it takes the reset
  // like any other state; unused entries must read 4'hF straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= EMPTY_CODE;
      count_q <= '0;
      ready_q <= 1'b0;
    end else if (bus.clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= EMPTY_CODE;
      count_q <= '0;
      // One dead cycle after a clear so the host sees the clear complete.
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        // NOTE: non-blocking assignments make every entry read its neighbour's
        // old value, so the whole buffer shifts by exactly one place per edge.
        for (int i = NUM_DIGITS - 1; i > 0; i--) digit_buf[i] <= digit_buf[i-1];
        digit_buf[0] <= bus.wr_data;
        // Full buffer still accepts; the oldest digit falls off the end.
        if (count_q != COUNT_FULL) count_q <= count_q + 4'd1;
      end
    end
  end

  assign bus.wr_ready = ready_q;
  assign buf_count    = count_q;

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state. The slot counter free-runs 0..SCAN_DIV-1 and is
  // untouched by writes or clears.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: outputs. Decoded from the next scan position so the registered
  // enables line up with the slot counter, but from the current buffer so a
  // buffer update reaches the pins one cycle after it lands. Selection is a
  // compare loop rather than a direct index so the slot index width need not
  // match the buffer depth. Only one enable bit can ever be cleared.
  // ---------------------------------------------------------------------------
  logic [7:0] seg_en_d;
  logic [3:0] key_d;

  always_comb begin
    seg_en_d = 8'hFF;
    key_d    = EMPTY_CODE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == 3'(i) && {1'b0, idx_d} < count_q) begin
        key_d = digit_buf[i];
        if (state_d == ST_SHOW) seg_en_d[i] = 1'b0;
      end
    end
  end

  logic [7:0] seg_en_q;
  logic [3:0] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_en_q <= 8'hFF;
      key_q    <= EMPTY_CODE;
    end else begin
      seg_en_q <= seg_en_d;
      key_q    <= key_d;
    end
  end

  assign seg_en    = seg_en_q;
  assign digit_key = key_q;
  assign scan_idx  = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
//   A behavioural model tracks the edges since reset release and derives the
//   slot and slot position arithmetically; a compare process checks every
//   output against it on each falling edge. Directed tests add hand-computed
//   literal expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_key;
  logic [7:0] seg_en;
  logic [2:0] scan_idx;
  logic [3:0] buf_count;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .digit_key(digit_key),
    .seg_en   (seg_en),
    .scan_idx (scan_idx),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [3:0] m_buf [ND];
  logic [3:0] p_buf [ND];
  int         m_count, p_count, m_ticks;
  bit         m_ready;
  logic [7:0] exp_seg;
  logic [3:0] exp_key;
  logic [2:0] exp_idx;

  task automatic model_outputs();
    int slot, pos;
    slot    = (m_ticks / SD) % ND;
    pos     = m_ticks % SD;
    exp_idx = 3'(slot);
    // Display reflects the buffer as it stood before the latest edge.
    exp_key = (slot < p_count) ? p_buf[slot] : 4'hF;
    exp_seg = (pos >= BC && slot < p_count) ? ~(8'b1 << slot) : 8'hFF;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_buf[i] = 4'hF;
      p_buf[i] = 4'hF;
    end
    m_count = 0;
    p_count = 0;
    m_ticks = 0;
    m_ready = 1'b0;
    model_outputs();
  endtask

  task automatic model_step();
    p_buf   = m_buf;
    p_count = m_count;
    if (bus.clr) begin
      for (int i = 0; i < ND; i++) m_buf[i] = 4'hF;
      m_count = 0;
      m_ready = 1'b0;
    end else begin
      if (bus.wr_en && m_ready) begin
        for (int i = ND - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = bus.wr_data;
        if (m_count < ND) m_count++;
      end
      m_ready = 1'b1;
    end
    m_ticks++;
    model_outputs();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Continuous compare, away from the active edge
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      check("seg_en",    32'(seg_en),    32'(exp_seg));
      check("digit_key", 32'(digit_key), 32'(exp_key));
      check("scan_idx",  32'(scan_idx),  32'(exp_idx));
      check("buf_count", 32'(buf_count), 32'(m_count));
      check("wr_ready",  32'(bus.wr_ready), 32'(m_ready));
      check("one_low",   32'($countones(~seg_en) <= 1), 32'd1);
      if (!rst && (m_ticks % SD) < BC) check("blank_guard", 32'(seg_en), 32'hFF);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Leaves the bench on the falling edge right after release (0 edges seen).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 4'h0;
    bus.clr     = 1'b0;

    // Reset state
    tick(2);
    check("rst_seg",   32'(seg_en),       32'hFF);
    check("rst_key",   32'(digit_key),    32'hF);
    check("rst_idx",   32'(scan_idx),     32'd0);
    check("rst_count", 32'(buf_count),    32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd0);
    rst = 1'b0;

    // Idle scanning with an empty buffer
    tick(1);
    check("idle_ready_e1", 32'(bus.wr_ready), 32'd1);
    check("idle_idx_e1",   32'(scan_idx),     32'd0);
    tick(7);
    check("idle_idx_e8",   32'(scan_idx),     32'd1);
    tick(8);
    check("idle_idx_e16",  32'(scan_idx),     32'd2);
    tick(8);
    check("idle_idx_e24",  32'(scan_idx),     32'd3);
    tick(8);
    check("idle_idx_e32",  32'(scan_idx),     32'd0);
    check("idle_seg_e32",  32'(seg_en),       32'hFF);
    check("idle_key_e32",  32'(digit_key),    32'hF);

    // Write 3 then 7
    do_reset();
    tick(1);
    write(4'd3);
    write(4'd7);
    check("w37_count",  32'(buf_count), 32'd2);
    check("w37_model0", 32'(m_buf[0]),  32'd7);
    check("w37_model1", 32'(m_buf[1]),  32'd3);
    tick(3);   // edge 6: slot 0, position 6
    check("w37_s0_seg", 32'(seg_en),    32'hFE);
    check("w37_s0_key", 32'(digit_key), 32'd7);
    tick(2);   // edge 8: slot 1 guard
    check("w37_s1_blank", 32'(seg_en),  32'hFF);
    check("w37_s1_bkey",  32'(digit_key), 32'd3);
    tick(2);   // edge 10: slot 1, position 2
    check("w37_s1_seg", 32'(seg_en),    32'hFD);
    check("w37_s1_key", 32'(digit_key), 32'd3);
    tick(8);   // edge 18: slot 2, empty
    check("w37_s2_seg", 32'(seg_en),    32'hFF);
    check("w37_s2_key", 32'(digit_key), 32'hF);
    tick(8);   // edge 26: slot 3, empty
    check("w37_s3_seg", 32'(seg_en),    32'hFF);

    // Saturation: 1..5, oldest dropped
    do_reset();
    tick(1);
    for (int v = 1; v <= 5; v++) write(4'(v));
    check("sat_count",  32'(buf_count), 32'd4);
    check("sat_model0", 32'(m_buf[0]),  32'd5);
    check("sat_model3", 32'(m_buf[3]),  32'd2);
    tick(28);  // edge 34: slot 0
    check("sat_s0_seg", 32'(seg_en),    32'hFE);
    check("sat_s0_key", 32'(digit_key), 32'd5);
    tick(8);
    check("sat_s1_seg", 32'(seg_en),    32'hFD);
    check("sat_s1_key", 32'(digit_key), 32'd4);
    tick(8);
    check("sat_s2_seg", 32'(seg_en),    32'hFB);
    check("sat_s2_key", 32'(digit_key), 32'd3);
    tick(8);
    check("sat_s3_seg", 32'(seg_en),    32'hF7);
    check("sat_s3_key", 32'(digit_key), 32'd2);

    // clr together with a write; then a write while wr_ready=0
    bus.clr     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 4'd9;
    @(negedge clk);
    bus.clr     = 1'b0;
    bus.wr_data = 4'd8;
    check("clr_count", 32'(buf_count),    32'd0);
    check("clr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("clr_ignored_count", 32'(buf_count),    32'd0);
    check("clr_ready_back",    32'(bus.wr_ready), 32'd1);
    check("clr_seg_off",       32'(seg_en),       32'hFF);
    write(4'd6);
    check("clr_next_write",    32'(buf_count),    32'd1);
    check("clr_model0",        32'(m_buf[0]),     32'd6);

    // Reset during SHOW of slot 2 with three digits
    do_reset();
    tick(1);
    write(4'd1);
    write(4'd2);
    write(4'd3);
    tick(15);  // edge 19: slot 2, position 3
    check("rst2_pre_seg", 32'(seg_en),    32'hFB);
    check("rst2_pre_key", 32'(digit_key), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst2_seg",   32'(seg_en),       32'hFF);
    check("rst2_count", 32'(buf_count),    32'd0);
    check("rst2_idx",   32'(scan_idx),     32'd0);
    check("rst2_key",   32'(digit_key),    32'hF);
    check("rst2_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    write(4'd5);   // sampled while wr_ready=0
    check("rst2_ignored", 32'(buf_count),    32'd0);
    check("rst2_ready1",  32'(bus.wr_ready), 32'd1);
    tick(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed 7-segment digits; legal values are 2..8.
REQ-002 The block SHALL have parameter SCAN_DIV, default 100000, giving the clock cycles each digit slot lasts.
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 16, giving the all-off guard cycles at the start of each slot; BLANK_CYCLES < SCAN_DIV is required.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 wr_en  input  1  write strobe; pushes wr_data into the digit buffer when wr_ready=1.
REQ-007 wr_data  input  4  decoded character code, 0..9 or other (other codes render through the decoder default).
REQ-008 clr  input  1  single-cycle synchronous buffer clear.
REQ-009 wr_ready  output  1  registered; 1 = write accepted this cycle.
REQ-010 digit_key  output  4  registered code of the currently scanned digit, feeding the segment decoder key input.
REQ-011 seg_en  output  8  registered active-low digit enables; bit i = digit i; bits >= NUM_DIGITS held 1.
REQ-012 scan_idx  output  3  registered index of the current digit slot.
REQ-013 buf_count  output  4  registered count of valid digits, 0..NUM_DIGITS.

Function
REQ-014 Buffer: NUM_DIGITS 4-bit entries; accepted write stores wr_data in entry 0 and shifts entry i to i+1; entry NUM_DIGITS-1 is discarded when full.
REQ-015 buf_count SHALL increment by 1 per accepted write and saturate at NUM_DIGITS; writes at full are still accepted (oldest digit dropped).
REQ-016 clr SHALL set all entries to 4'hF and buf_count to 0 on the next edge; wr_ready SHALL be 0 in the cycle after clr is sampled, then return to 1.
REQ-017 clr and wr_en in the same cycle: clr wins, write is dropped, buffer ends empty.
REQ-018 wr_en while wr_ready=0: ignored, no state change.
REQ-019 Scan FSM states: BLANK and SHOW; a slot counter counts 0..SCAN_DIV-1 within each slot.
REQ-020 BLANK: seg_en all 1 for counter 0..BLANK_CYCLES-1; then transition to SHOW.
REQ-021 SHOW: for counter BLANK_CYCLES..SCAN_DIV-1, seg_en bit scan_idx = 0 only if scan_idx < buf_count, else all 1.
REQ-022 At counter = SCAN_DIV-1 in SHOW: counter to 0, state to BLANK, scan_idx increments, wrapping NUM_DIGITS-1 -> 0.
REQ-023 digit_key SHALL equal buffer entry scan_idx, updated every cycle (1-cycle latency from buffer change to digit_key); entries >= buf_count read 4'hF.
REQ-024 Writes/clears mid-SHOW SHALL take effect on digit_key and seg_en one cycle later without disturbing counter, state or scan_idx.
REQ-025 Exactly one seg_en bit SHALL be 0 at any time, or none; never two.

Reset
REQ-026 rst=1 SHALL asynchronously force: all entries 4'hF, buf_count 0, scan_idx 0, counter 0, state BLANK, seg_en 8'hFF, digit_key 4'hF, wr_ready 0.
REQ-027 wr_ready SHALL rise to 1 on the first edge after rst deasserts; reset mid-slot or mid-write SHALL abandon the operation with no partial update.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
REQ-028 Reset release, no writes -> seg_en stays 8'hFF, digit_key 4'hF, scan_idx cycles 0,1,2,3,0 every 8 cycles.
REQ-029 Write 3 then 7 -> buf_count 2, entry0=7, entry1=3; slot 0 shows digit_key 7 with seg_en 8'hFE on counter 2..7, slot 1 shows 3 with 8'hFD, slots 2-3 all off.
REQ-030 Write 1,2,3,4,5 -> buf_count saturates at 4, entries 0..3 = 5,4,3,2; value 1 discarded.
REQ-031 clr and wr_en=1, wr_data=9 same cycle -> buf_count 0, all seg_en 1, wr_ready 0 for one cycle, next write accepted.
REQ-032 Assert rst during SHOW of slot 2 with buf_count 3 -> immediately seg_en 8'hFF, buf_count 0, scan_idx 0; write on first cycle after release (wr_ready=0) is ignored.
REQ-033 Continuous check over all tests: never more than one seg_en bit low; seg_en all 1 for counter < BLANK_CYCLES.
